ras_spec_tracker: RTL

- Front-end stage directly upstream of the return-address stack (RAS).
- Pre-decodes each fetched instruction as call, return, swap or none, and drives the RAS push/pop strobes with the return address (pc + 4).
- Records every speculative RAS operation in a small in-order FIFO.
- On a pipeline flush, walks that FIFO youngest-first and issues one rollback strobe per cycle, restoring the RAS pointer before fetch resumes.

---
 rtl/ras_spec_tracker_if.sv | 46 ++++
 rtl/ras_spec_tracker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ras_spec_tracker_if.sv
// Fetch-side and RAS-side signal bundle for ras_spec_tracker.
// master = fetch/control side, slave = the tracker itself.
interface ras_spec_tracker_if;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        commit_ras;
    logic        flush;
    logic        push;
    logic        pop;
    logic        rollback_push;
    logic        rollback_pop;
    logic [31:0] pc_add_4;
    logic        stall_req;
    logic        busy;

    modport master (
        output fetch_valid,
        output fetch_instr,
        output fetch_pc,
        output commit_ras,
        output flush,
        input  push,
        input  pop,
        input  rollback_push,
        input  rollback_pop,
        input  pc_add_4,
        input  stall_req,
        input  busy
    );

    modport slave (
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_pc,
        input  commit_ras,
        input  flush,
        output push,
        output pop,
        output rollback_push,
        output rollback_pop,
        output pc_add_4,
        output stall_req,
        output busy
    );
endinterface

// File: rtl/ras_spec_tracker.sv
// RAS pre-decode, speculative op FIFO and youngest-first flush rollback.
// Optional RAS_SWAP_EN: store link-to-link JALR with rd != rs1 as SWAP.
module ras_spec_tracker #(
    parameter int TRACK_DEPTH      = 8,
    parameter int TRACK_ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    ras_spec_tracker_if.slave bus
);

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_PUSH = 2'b01;
    localparam logic [1:0] CLS_POP  = 2'b10;
    localparam logic [1:0] CLS_SWAP = 2'b11;

`ifdef RAS_SWAP_EN
    localparam logic [1:0] CLS_XLINK = CLS_SWAP;
`else
    localparam logic [1:0] CLS_XLINK = CLS_PUSH;
`endif

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_ROLLBACK = 1'b1;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [TRACK_ADDR_WIDTH:0] FULL_CNT =
        (TRACK_ADDR_WIDTH+1)'(TRACK_DEPTH);

    logic [6:0]                  opc;
    logic [4:0]                  rd;
    logic [4:0]                  rs1;
    logic [2:0]                  f3;
    logic                        rd_link;
    logic                        rs1_link;
    logic                        is_jal;
    logic                        is_jalr;
    logic [1:0]                  cls;
    logic                        unused_imm;

    logic [1:0]                  mem [TRACK_DEPTH];
    logic [TRACK_ADDR_WIDTH-1:0] head;
    logic [TRACK_ADDR_WIDTH-1:0] tail;
    logic [TRACK_ADDR_WIDTH-1:0] tail_m1;
    logic [TRACK_ADDR_WIDTH:0]   count;
    logic [TRACK_ADDR_WIDTH:0]   count_left;
    logic [0:0]                  state;
    logic [1:0]                  youngest;

    logic                        idle;
    logic                        full;
    logic                        has_op;
    logic                        accept;
    logic                        do_commit;

    logic                        push_q;
    logic                        pop_q;
    logic [31:0]                 pc_q;

    assign opc        = bus.fetch_instr[6:0];
    assign rd         = bus.fetch_instr[11:7];
    assign f3         = bus.fetch_instr[14:12];
    assign rs1        = bus.fetch_instr[19:15];
    assign unused_imm = ^bus.fetch_instr[31:20];

    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign is_jal   = (opc == OP_JAL);
    assign is_jalr  = (opc == OP_JALR) && (f3 == 3'b000);

    always_comb begin
        cls = CLS_NONE;
        unique case (1'b1)
            is_jal: begin
                cls = rd_link ? CLS_PUSH : CLS_NONE;
            end
            is_jalr: begin
                unique case ({rd_link, rs1_link})
                    2'b01:   cls = CLS_POP;
                    2'b10:   cls = CLS_PUSH;
                    2'b11:   cls = (rd == rs1) ? CLS_PUSH : CLS_XLINK;
                    default: cls = CLS_NONE;
                endcase
            end
            default: cls = CLS_NONE;
        endcase
    end

    assign idle      = (state == S_IDLE);
    assign full      = (count == FULL_CNT);
    assign has_op    = bus.fetch_valid && (cls != CLS_NONE);
    assign accept    = idle && has_op && !bus.flush && !full;
    assign do_commit = idle && bus.commit_ras && (count != '0);

    assign count_left = count - {{TRACK_ADDR_WIDTH{1'b0}}, do_commit};
    assign tail_m1    = tail - 1'b1;
    assign youngest   = mem[tail_m1];

    // Stall is based on the registered count only, so a same-cycle
    // commit never opens a slot for the instruction being stalled.
    assign bus.stall_req = idle ? (full && has_op) : bus.fetch_valid;

    assign bus.busy          = !idle;
    assign bus.rollback_pop  = !idle && (youngest == CLS_PUSH);
    assign bus.rollback_push = !idle && (youngest == CLS_POP);
    assign bus.push          = push_q;
    assign bus.pop           = pop_q;
    assign bus.pc_add_4      = pc_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[tail] <= cls;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            pc_q   <= '0;
        end else begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (do_commit) begin
                        head <= head + 1'b1;
                    end
                    if (bus.flush) begin
                        count <= count_left;
                        if (count_left != '0) begin
                            state <= S_ROLLBACK;
                        end
                    end else begin
                        count <= count_left
                               + {{TRACK_ADDR_WIDTH{1'b0}}, accept};
                        if (accept) begin
                            tail   <= tail + 1'b1;
                            push_q <= cls[0];
                            pop_q  <= cls[1];
                            pc_q   <= bus.fetch_pc + 32'd4;
                        end
                    end
                end
                S_ROLLBACK: begin
                    tail  <= tail_m1;
                    count <= count - 1'b1;
                    if (count == {{TRACK_ADDR_WIDTH{1'b0}}, 1'b1}) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
